out_port_demux: RTL and testbench

- Write-side counterpart to the 4-input 8-bit input-port mux.
- Takes one 8-bit value plus a 2-bit port select from the CPU's OUT path and steers it into one of four registered output channels.
- Each channel holds its data and raises VALID until the downstream peripheral (LEDs, SSEG, etc.) pulses ACK.
- Back-pressures the CPU when the addressed channel is still occupied; flags peripherals that never acknowledge.

---
 rtl/out_port_pkg.sv | 19 +
 rtl/out_channel.sv | 98 +++++++++
 rtl/out_port_demux.sv | 72 +++++++
 tb/tb_out_port_demux.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared definitions for the output-port demultiplexer.
//   NUM_PORTS          : number of output channels
//   PORT_A .. PORT_D   : channel indices as carried on PORT_SEL
//   chan_state_t       : per-channel occupancy state (IDLE / HOLD)
package out_port_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;
  localparam logic [1:0] PORT_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_t;

endpackage

// File: rtl/out_channel.sv
// One output channel: data register, IDLE/HOLD state, hold timer and a
// sticky timeout flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i       : accepted write addressed to this channel
//   data_i        : write data
//   ack_i         : single-cycle consume pulse from the peripheral
//   err_clr_i     : clears the sticky timeout flag
//   data_o        : registered channel data (kept after ACK / timeout)
//   state_o       : current channel state (VALID is state_o == HOLD)
//   err_o         : sticky timeout flag
module out_channel
  import out_port_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ack_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] data_o,
  output chan_state_t      state_o,
  output logic             err_o
);

  // Last timer value before the hold expires; timer is 8 bits wide.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       timer_q, timer_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    timer_d     = timer_q;
    err_d       = err_q;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_en_i) begin
          state_d = HOLD;
          data_d  = data_i;
          timer_d = '0;
        end
      end
      HOLD: begin
        // A write into an occupied channel only arrives together with its
        // ACK, so refilling takes priority and restarts the hold timer.
        if (wr_en_i) begin
          data_d  = data_i;
          timer_d = '0;
        end else if (ack_i) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = IDLE;
          timer_d     = '0;
          timeout_hit = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting on timeout wins over a simultaneous clear.
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign state_o = state_q;
  assign err_o   = err_q;

endmodule

// File: rtl/out_port_demux.sv
// Steers one CPU OUT write into one of four registered output channels and
// back-pressures the CPU while the addressed channel is still occupied.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_DATA, PORT_SEL   : write data and target channel (0=A .. 3=D)
//   WR_STRB, WR_READY   : CPU write request / addressed channel can accept
//   OUT_A .. OUT_D      : registered channel data
//   VALID, ACK          : per-channel data pending / consume pulse
//   ERR, ERR_CLR        : per-channel sticky timeout flag / clear pulse
//
// Handshake: a write transfers on a rising edge where WR_STRB && WR_READY.
// WR_READY is combinational and true when the addressed channel is empty or
// is being acknowledged in the same cycle. A stalled CPU keeps WR_STRB,
// PORT_SEL and IN_DATA stable until the transfer happens. Downstream, VALID[i]
// stays high until the peripheral pulses ACK[i] for one cycle.
module out_port_demux
  import out_port_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     IN_DATA,
  input  logic [1:0]           PORT_SEL,
  input  logic                 WR_STRB,
  output logic                 WR_READY,
  output logic [WIDTH-1:0]     OUT_A,
  output logic [WIDTH-1:0]     OUT_B,
  output logic [WIDTH-1:0]     OUT_C,
  output logic [WIDTH-1:0]     OUT_D,
  output logic [NUM_PORTS-1:0] VALID,
  input  logic [NUM_PORTS-1:0] ACK,
  output logic [NUM_PORTS-1:0] ERR,
  input  logic [NUM_PORTS-1:0] ERR_CLR
);

  chan_state_t          chan_state [NUM_PORTS];
  logic [WIDTH-1:0]     chan_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_en;
  logic                 accept;

  always_comb begin
    WR_READY        = !VALID[PORT_SEL] || ACK[PORT_SEL];
    accept          = WR_STRB && WR_READY;
    wr_en           = '0;
    wr_en[PORT_SEL] = accept;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
    out_channel #(
      .WIDTH  (WIDTH),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .wr_en_i  (wr_en[i]),
      .data_i   (IN_DATA),
      .ack_i    (ACK[i]),
      .err_clr_i(ERR_CLR[i]),
      .data_o   (chan_data[i]),
      .state_o  (chan_state[i]),
      .err_o    (ERR[i])
    );
    assign VALID[i] = (chan_state[i] == HOLD);
  end

  assign OUT_A = chan_data[PORT_A];
  assign OUT_B = chan_data[PORT_B];
  assign OUT_C = chan_data[PORT_C];
  assign OUT_D = chan_data[PORT_D];

endmodule

// File: tb/tb_out_port_demux.sv
module tb_out_port_demux;

  localparam int W          = 8;
  localparam int TB_TIMEOUT = 6;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] IN_DATA = '0;
  logic [1:0]   PORT_SEL = '0;
  logic         WR_STRB = 1'b0;
  logic [3:0]   ACK = '0;
  logic [3:0]   ERR_CLR = '0;
  logic         WR_READY;
  logic [W-1:0] OUT_A, OUT_B, OUT_C, OUT_D;
  logic [3:0]   VALID, ERR;

  // clock / reset block
  always #5 CLK = ~CLK;

  out_port_demux #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .PORT_SEL(PORT_SEL),
    .WR_STRB(WR_STRB), .WR_READY(WR_READY),
    .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_C(OUT_C), .OUT_D(OUT_D),
    .VALID(VALID), .ACK(ACK), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  logic [W-1:0] dut_out [4];
  always_comb begin
    dut_out[0] = OUT_A;
    dut_out[1] = OUT_B;
    dut_out[2] = OUT_C;
    dut_out[3] = OUT_D;
  end

  // Reference model: a channel is pending from the edge it is filled until
  // it is acknowledged, refilled, or TB_TIMEOUT edges have gone by.
  logic [W-1:0] m_data [4];
  bit           m_valid [4];
  int           m_deadline [4];
  bit           m_err [4];
  int           cyc = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [3:0] m_err_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_err[i];
    return v;
  endfunction

  function automatic logic m_ready();
    return !m_valid[PORT_SEL] || ACK[PORT_SEL];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_valid[i] = 1'b0;
      m_deadline[i] = 0;
      m_err[i] = 1'b0;
    end
  endtask

  // driver: advance one clock edge, updating the model with the inputs
  // present before the edge; ACK and ERR_CLR are single-cycle pulses.
  task automatic step();
    logic acc;
    acc = WR_STRB && m_ready();
    cyc++;
    for (int ch = 0; ch < 4; ch++) begin
      bit expire;
      expire = 1'b0;
      if (acc && PORT_SEL == 2'(ch)) begin
        m_data[ch] = IN_DATA;
        m_valid[ch] = 1'b1;
        m_deadline[ch] = cyc + TB_TIMEOUT;
      end else if (m_valid[ch]) begin
        if (ACK[ch]) m_valid[ch] = 1'b0;
        else if (cyc == m_deadline[ch]) begin
          m_valid[ch] = 1'b0;
          expire = 1'b1;
        end
      end
      if (expire) m_err[ch] = 1'b1;
      else if (ERR_CLR[ch]) m_err[ch] = 1'b0;
    end
    @(posedge CLK);
    #1;
    ACK = '0;
    ERR_CLR = '0;
  endtask

  task automatic write_one(input logic [1:0] sel, input logic [W-1:0] d);
    PORT_SEL = sel;
    IN_DATA = d;
    WR_STRB = 1'b1;
    step();
    WR_STRB = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    WR_STRB = 1'b0;
    ACK = '0;
    ERR_CLR = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (VALID !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", VALID); end
    n_cmp++;
    if (ERR !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", ERR); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_out[i] !== 8'h00) begin n_fail++; $display("FAIL reset_out%0d: got %h want 00", i, dut_out[i]); end
    end
    RST_N = 1'b1;
  endtask

  task automatic test_write_ack();
    do_reset();
    PORT_SEL = 2'd2; IN_DATA = 8'hA5; WR_STRB = 1'b1;
    #1;
    n_cmp++;
    if (WR_READY !== 1'b1) begin n_fail++; $display("FAIL wa_ready: got %b want 1", WR_READY); end
    step();
    WR_STRB = 1'b0;
    n_cmp++;
    if (VALID !== 4'b0100) begin n_fail++; $display("FAIL wa_valid: got %b want 0100", VALID); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_out[i] !== (i == 2 ? 8'hA5 : 8'h00)) begin
        n_fail++; $display("FAIL wa_out%0d: got %h want %h", i, dut_out[i], (i == 2 ? 8'hA5 : 8'h00));
      end
    end
    ACK = 4'b0100;
    step();
    n_cmp++;
    if (VALID !== 4'b0000) begin n_fail++; $display("FAIL wa_ack_valid: got %b want 0000", VALID); end
    n_cmp++;
    if (OUT_C !== 8'hA5) begin n_fail++; $display("FAIL wa_ack_keep: got %h want a5", OUT_C); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    write_one(2'd0, 8'h11);
    PORT_SEL = 2'd0; IN_DATA = 8'h22; WR_STRB = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (WR_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall%0d: got %b want 0", k, WR_READY); end
      step();
      n_cmp++;
      if (OUT_A !== 8'h11 || VALID[0] !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h/%b want 11/1", k, OUT_A, VALID[0]);
      end
    end
    // Refill coincides with the last timer cycle: the write must win.
    ACK = 4'b0001;
    #1;
    n_cmp++;
    if (WR_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_ack: got %b want 1", WR_READY); end
    step();
    WR_STRB = 1'b0;
    n_cmp++;
    if (OUT_A !== 8'h22 || VALID[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_refill: got %h/%b want 22/1", OUT_A, VALID[0]);
    end
    n_cmp++;
    if (ERR !== 4'b0000) begin n_fail++; $display("FAIL bp_err: got %b want 0000", ERR); end
  endtask

  task automatic test_timeout();
    do_reset();
    write_one(2'd3, 8'h3C);
    for (int k = 1; k < TB_TIMEOUT; k++) begin
      step();
      n_cmp++;
      if (VALID[3] !== 1'b1 || ERR !== 4'b0000) begin
        n_fail++; $display("FAIL to_hold%0d: got %b/%b want 1/0000", k, VALID[3], ERR);
      end
    end
    step();
    n_cmp++;
    if (VALID[3] !== 1'b0 || ERR !== 4'b1000) begin
      n_fail++; $display("FAIL to_expire: got %b/%b want 0/1000", VALID[3], ERR);
    end
    n_cmp++;
    if (OUT_D !== 8'h3C) begin n_fail++; $display("FAIL to_keep: got %h want 3c", OUT_D); end
    // ERR does not block; a clear coinciding with a new timeout loses.
    PORT_SEL = 2'd3;
    #1;
    n_cmp++;
    if (WR_READY !== 1'b1) begin n_fail++; $display("FAIL to_ready_err: got %b want 1", WR_READY); end
    write_one(2'd3, 8'h77);
    repeat (TB_TIMEOUT - 1) step();
    ERR_CLR = 4'b1000;
    step();
    n_cmp++;
    if (ERR !== 4'b1000 || VALID[3] !== 1'b0) begin
      n_fail++; $display("FAIL to_set_wins: got %b/%b want 1000/0", ERR, VALID[3]);
    end
    ERR_CLR = 4'b1000;
    step();
    n_cmp++;
    if (ERR !== 4'b0000) begin n_fail++; $display("FAIL to_clear: got %b want 0000", ERR); end
    // ACK on the final cycle beats the timeout.
    write_one(2'd3, 8'h5A);
    repeat (TB_TIMEOUT - 1) step();
    ACK = 4'b1000;
    step();
    n_cmp++;
    if (ERR !== 4'b0000 || VALID[3] !== 1'b0) begin
      n_fail++; $display("FAIL to_ack_wins: got %b/%b want 0000/0", ERR, VALID[3]);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    for (int i = 0; i < 4; i++) write_one(2'(i), 8'(i + 1));
    n_cmp++;
    if (VALID !== 4'hF) begin n_fail++; $display("FAIL par_valid: got %b want 1111", VALID); end
    ACK = 4'b1010;
    step();
    n_cmp++;
    if (VALID !== 4'b0101) begin n_fail++; $display("FAIL par_ack: got %b want 0101", VALID); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut_out[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL par_data%0d: got %h want %h", i, dut_out[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_one(2'd0, 8'h5E);
    write_one(2'd1, 8'h6F);
    n_cmp++;
    if (VALID !== 4'b0011) begin n_fail++; $display("FAIL ar_pre: got %b want 0011", VALID); end
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (VALID !== 4'b0000 || ERR !== 4'b0000 || OUT_A !== 8'h00 || OUT_B !== 8'h00) begin
      n_fail++; $display("FAIL ar_clear: got %b/%b/%h/%h want 0000/0000/00/00", VALID, ERR, OUT_A, OUT_B);
    end
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_spurious_ack();
    do_reset();
    ACK = 4'hF;
    step();
    n_cmp++;
    if (VALID !== 4'b0000 || ERR !== 4'b0000) begin
      n_fail++; $display("FAIL sp_nochange: got %b/%b want 0000/0000", VALID, ERR);
    end
    write_one(2'd1, 8'hFF);
    n_cmp++;
    if (VALID !== 4'b0010 || OUT_B !== 8'hFF) begin
      n_fail++; $display("FAIL sp_write: got %b/%h want 0010/ff", VALID, OUT_B);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      PORT_SEL = 2'($urandom_range(0, 3));
      IN_DATA = 8'($urandom);
      WR_STRB = ($urandom_range(0, 2) != 0);
      for (int b = 0; b < 4; b++) begin
        ACK[b] = ($urandom_range(0, 5) == 0);
        ERR_CLR[b] = ($urandom_range(0, 7) == 0);
      end
      #1;
      n_cmp++;
      if (WR_READY !== m_ready()) begin
        n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", n, WR_READY, m_ready());
      end
      step();
      n_cmp++;
      if (VALID !== m_valid_vec() || ERR !== m_err_vec()) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got %b/%b want %b/%b", n, VALID, ERR, m_valid_vec(), m_err_vec());
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dut_out[i] !== m_data[i]) begin
          n_fail++; $display("FAIL rnd_data%0d@%0d: got %h want %h", i, n, dut_out[i], m_data[i]);
        end
      end
    end
    WR_STRB = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_back_pressure();
    test_timeout();
    test_parallel();
    test_async_reset();
    test_spurious_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
